// File: rtl/tilelink_n_to_1_pkg.sv
// Shared TileLink constants and the burst-length helper for the N:1 arbiter.
package tl_pkg;

  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;
  localparam logic [2:0] TL_ACK         = 3'd0;
  localparam logic [2:0] TL_ACK_DATA    = 3'd1;

  // Only Put bursts wider than one bus beat span multiple beats; sizes past 4 KiB collapse to one.
  function automatic logic [11:0] tl_beats(input logic [7:0] size, input logic [2:0] opcode,
                                           input int dw);
    int lg;
    lg = $clog2(dw / 8);
    if ((opcode == TL_PUT_FULL || opcode == TL_PUT_PARTIAL) && int'(size) > lg && size <= 8'd12)
      return 12'(1 << (int'(size) - lg));
    return 12'd1;
  endfunction

endpackage

// File: rtl/tilelink_n_to_1_if.sv
// TileLink-UL bundle of NP ports; master drives A and d_ready, slave drives D and a_ready.
interface tilelink_n_to_1_if #(
  parameter int NP = 1,
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int SW = 4,
  parameter int SZ = 4
);
  logic [NP-1:0][2:0]      a_opcode;
  logic [NP-1:0][2:0]      a_param;
  logic [NP-1:0][SZ-1:0]   a_size;
  logic [NP-1:0][SW-1:0]   a_source;
  logic [NP-1:0][AW-1:0]   a_address;
  logic [NP-1:0][DW/8-1:0] a_mask;
  logic [NP-1:0][DW-1:0]   a_data;
  logic [NP-1:0]           a_corrupt;
  logic [NP-1:0]           a_valid;
  logic [NP-1:0]           a_ready;

  logic [NP-1:0][2:0]      d_opcode;
  logic [NP-1:0][1:0]      d_param;
  logic [NP-1:0][SZ-1:0]   d_size;
  logic [NP-1:0][SW-1:0]   d_source;
  logic [NP-1:0]           d_denied;
  logic [NP-1:0][DW-1:0]   d_data;
  logic [NP-1:0]           d_corrupt;
  logic [NP-1:0]           d_valid;
  logic [NP-1:0]           d_ready;

  modport master (
    output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
    input  a_ready,
    input  d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid,
    output d_ready
  );

  modport slave (
    input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
    output a_ready,
    output d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid,
    input  d_ready
  );
endinterface

// File: rtl/tilelink_n_to_1_rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or after ptr wins.
module tl_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    int   j;
    logic hit;
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (en && !hit && req[j]) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/tilelink_n_to_1.sv
// N-master to 1-slave TileLink arbiter: round-robin A with burst lock into a registered
// slice, source-prefix tagging, and combinational D routing back by that prefix.
module tilelink_n_to_1
  import tl_pkg::*;
#(
  parameter int N     = 2,
  parameter int TL_DW = 32,
  parameter int TL_AW = 32,
  parameter int TL_RS = 4,
  parameter int TL_SZ = 4
) (
  input logic              tilelink_clock_i,
  input logic              tilelink_reset_i,
  tilelink_n_to_1_if.slave  mst_bus,
  tilelink_n_to_1_if.master slv_bus
);
  localparam int IW = $clog2(N);

  logic [N-1:0]       arb_gnt, a_rdy;
  logic [IW-1:0]      arb_idx, g, rr_ptr, lock_idx;
  logic               lock, slice_free, any_valid, accept;
  logic [11:0]        beat_cnt, beats;

  logic               s_valid, s_corrupt;
  logic [2:0]         s_opcode, s_param;
  logic [TL_SZ-1:0]   s_size;
  logic [TL_RS+IW-1:0] s_source;
  logic [TL_AW-1:0]   s_address;
  logic [TL_DW/8-1:0] s_mask;
  logic [TL_DW-1:0]   s_data;

  tl_rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req (mst_bus.a_valid),
    .ptr (rr_ptr),
    .en  (!lock),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign slice_free = !s_valid | slv_bus.a_ready[0];
  assign any_valid  = |mst_bus.a_valid;
  assign g          = lock ? lock_idx : arb_idx;
  assign beats      = tl_beats(8'(mst_bus.a_size[g]), mst_bus.a_opcode[g], TL_DW);

  // During a burst only the owner may be granted, even if it has dropped valid.
  always_comb begin
    a_rdy = '0;
    for (int i = 0; i < N; i++)
      a_rdy[i] = !tilelink_reset_i && slice_free && any_valid &&
                 (lock ? (lock_idx == IW'(i)) : arb_gnt[i]);
  end

  assign accept          = |(a_rdy & mst_bus.a_valid);
  assign mst_bus.a_ready = a_rdy;

  always_ff @(posedge tilelink_clock_i) begin
    if (tilelink_reset_i) begin
      s_valid  <= 1'b0;
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      s_valid <= 1'b1;
      if (lock) begin
        beat_cnt <= beat_cnt - 12'd1;
        if (beat_cnt == 12'd1) lock <= 1'b0;
      end else begin
        rr_ptr <= (int'(g) == N - 1) ? '0 : g + 1'b1;
        if (beats > 12'd1) begin
          lock     <= 1'b1;
          lock_idx <= g;
          beat_cnt <= beats - 12'd1;
        end
      end
    end else if (slv_bus.a_ready[0]) begin
      s_valid <= 1'b0;
    end
  end

  always_ff @(posedge tilelink_clock_i) begin
    if (accept) begin
      s_opcode  <= mst_bus.a_opcode[g];
      s_param   <= mst_bus.a_param[g];
      s_size    <= mst_bus.a_size[g];
      s_source  <= {g, mst_bus.a_source[g]};
      s_address <= mst_bus.a_address[g];
      s_mask    <= mst_bus.a_mask[g];
      s_data    <= mst_bus.a_data[g];
      s_corrupt <= mst_bus.a_corrupt[g];
    end
  end

  assign slv_bus.a_valid[0]   = s_valid;
  assign slv_bus.a_opcode[0]  = s_opcode;
  assign slv_bus.a_param[0]   = s_param;
  assign slv_bus.a_size[0]    = s_size;
  assign slv_bus.a_source[0]  = s_source;
  assign slv_bus.a_address[0] = s_address;
  assign slv_bus.a_mask[0]    = s_mask;
  assign slv_bus.a_data[0]    = s_data;
  assign slv_bus.a_corrupt[0] = s_corrupt;

  logic [IW-1:0] d_idx;
  assign d_idx = slv_bus.d_source[0][TL_RS+IW-1:TL_RS];

  for (genvar i = 0; i < N; i++) begin : g_d
    assign mst_bus.d_valid[i]   = slv_bus.d_valid[0] & (int'(d_idx) == i);
    assign mst_bus.d_source[i]  = slv_bus.d_source[0][TL_RS-1:0];
    assign mst_bus.d_opcode[i]  = slv_bus.d_opcode[0];
    assign mst_bus.d_param[i]   = slv_bus.d_param[0];
    assign mst_bus.d_size[i]    = slv_bus.d_size[0];
    assign mst_bus.d_denied[i]  = slv_bus.d_denied[0];
    assign mst_bus.d_data[i]    = slv_bus.d_data[0];
    assign mst_bus.d_corrupt[i] = slv_bus.d_corrupt[0];
  end

  // A prefix naming no master is sunk so a stray response cannot wedge the channel.
  always_comb begin
    slv_bus.d_ready[0] = 1'b1;
    for (int i = 0; i < N; i++)
      if (int'(d_idx) == i) slv_bus.d_ready[0] = mst_bus.d_ready[i];
  end

endmodule

// File: tb/tb_tilelink_n_to_1.sv
// Randomized and directed bench for tilelink_n_to_1 against a transaction-level model.
module tb_tilelink_n_to_1;
  logic clk, rst;
  int   checks, errors;

  tilelink_n_to_1_if #(.NP(2), .DW(32), .AW(32), .SW(4), .SZ(4)) mi ();
  tilelink_n_to_1_if #(.NP(1), .DW(32), .AW(32), .SW(5), .SZ(4)) si ();
  tilelink_n_to_1_if #(.NP(3), .DW(32), .AW(32), .SW(4), .SZ(4)) mi3 ();
  tilelink_n_to_1_if #(.NP(1), .DW(32), .AW(32), .SW(6), .SZ(4)) si3 ();

  tilelink_n_to_1 #(.N(2)) dut (
    .tilelink_clock_i (clk),
    .tilelink_reset_i (rst),
    .mst_bus          (mi),
    .slv_bus          (si)
  );

  tilelink_n_to_1 #(.N(3)) dut3 (
    .tilelink_clock_i (clk),
    .tilelink_reset_i (rst),
    .mst_bus          (mi3),
    .slv_bus          (si3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: slice contents, next-first-priority master, burst owner and beats left
  bit          m_valid, armed;
  logic [83:0] m_pay;
  int          m_ptr, m_owner, m_left;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_beats(input int op, input int sz);
    if ((op == 0 || op == 1) && sz > 2 && sz <= 12) return (1 << sz) / 4;
    return 1;
  endfunction

  task automatic model_step();
    int g, idx;
    bit free, any, acc;
    logic [1:0] er, ed;
    idx = int'(si.d_source[0][4]);
    ed  = si.d_valid[0] ? 2'(1 << idx) : 2'b00;
    chk("d_valid", mi.d_valid, ed);
    chk("d_ready", si.d_ready[0], mi.d_ready[idx]);
    for (int i = 0; i < 2; i++)
      chk("d_fields", {mi.d_opcode[i], mi.d_param[i], mi.d_size[i], mi.d_source[i],
                       mi.d_denied[i], mi.d_data[i], mi.d_corrupt[i]},
                      {si.d_opcode[0], si.d_param[0], si.d_size[0], si.d_source[0][3:0],
                       si.d_denied[0], si.d_data[0], si.d_corrupt[0]});
    g = -1; free = 0; any = 0; er = 2'b00;
    if (!rst) begin
      free = !m_valid || si.a_ready[0];
      any  = |mi.a_valid;
      if (m_owner >= 0) g = m_owner;
      else
        for (int k = 0; k < 2; k++)
          if (g < 0 && mi.a_valid[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
      if (free && any && g >= 0) er = 2'(1 << g);
    end
    chk("a_ready", mi.a_ready, er);
    if (armed) begin
      chk("s_valid", si.a_valid[0], m_valid);
      if (m_valid)
        chk("s_payload", {si.a_opcode[0], si.a_param[0], si.a_size[0], si.a_source[0],
                          si.a_address[0], si.a_mask[0], si.a_data[0], si.a_corrupt[0]}, m_pay);
    end
    if (rst) begin
      m_valid = 0; m_ptr = 0; m_owner = -1; m_left = 0; armed = 1;
    end else begin
      acc = g >= 0 && free && mi.a_valid[g];
      if (acc) begin
        m_valid = 1;
        m_pay = {mi.a_opcode[g], mi.a_param[g], mi.a_size[g], 1'(g), mi.a_source[g],
                 mi.a_address[g], mi.a_mask[g], mi.a_data[g], mi.a_corrupt[g]};
        if (m_owner >= 0) begin
          m_left--;
          if (m_left == 0) m_owner = -1;
        end else begin
          m_ptr = (g + 1) % 2;
          if (exp_beats(int'(mi.a_opcode[g]), int'(mi.a_size[g])) > 1) begin
            m_owner = g;
            m_left  = exp_beats(int'(mi.a_opcode[g]), int'(mi.a_size[g])) - 1;
          end
        end
      end else if (si.a_ready[0]) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op, input logic [3:0] sz,
                         input logic [3:0] src, input logic [31:0] dat);
    mi.a_valid[i]   = v;
    mi.a_opcode[i]  = op;
    mi.a_param[i]   = 3'd0;
    mi.a_size[i]    = sz;
    mi.a_source[i]  = src;
    mi.a_address[i] = 32'h1000 * (i + 1);
    mi.a_mask[i]    = 4'hF;
    mi.a_data[i]    = dat;
    mi.a_corrupt[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mi.a_valid = '0;
    settle();
    advance();
    rst = 1'b0;
  endtask

  task automatic rand_inputs();
    logic [2:0] op;
    for (int i = 0; i < 2; i++) begin
      case ($urandom_range(0, 2))
        0: op = 3'd0;
        1: op = 3'd1;
        default: op = 3'd4;
      endcase
      mi.a_valid[i]   = $urandom_range(0, 9) < 7;
      mi.a_opcode[i]  = op;
      mi.a_param[i]   = 3'($urandom);
      mi.a_size[i]    = ($urandom_range(0, 19) == 0) ? 4'(13 + $urandom_range(0, 2))
                                                     : 4'($urandom_range(0, 5));
      mi.a_source[i]  = 4'($urandom);
      mi.a_address[i] = $urandom;
      mi.a_mask[i]    = 4'($urandom);
      mi.a_data[i]    = $urandom;
      mi.a_corrupt[i] = 1'($urandom);
    end
    si.a_ready[0]   = $urandom_range(0, 3) != 0;
    si.d_valid[0]   = 1'($urandom);
    si.d_source[0]  = 5'($urandom);
    si.d_opcode[0]  = 3'($urandom);
    si.d_param[0]   = 2'($urandom);
    si.d_size[0]    = 4'($urandom);
    si.d_denied[0]  = 1'($urandom);
    si.d_data[0]    = $urandom;
    si.d_corrupt[0] = 1'($urandom);
    mi.d_ready      = 2'($urandom);
    rst             = $urandom_range(0, 299) == 0;
  endtask

  logic [1:0] t1_rdy [4];
  logic [4:0] t1_src [4];

  initial begin
    checks = 0; errors = 0;
    armed = 0; m_valid = 0; m_ptr = 0; m_owner = -1; m_left = 0; m_pay = '0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 3'd4, 4'd2, 4'd0, 32'd0);
    si.a_ready = 1'b1;
    si.d_valid = '0; si.d_source = '0; si.d_opcode = '0; si.d_param = '0; si.d_size = '0;
    si.d_denied = '0; si.d_data = '0; si.d_corrupt = '0;
    mi.d_ready = '0;
    mi3.a_valid = '0; mi3.a_opcode = '0; mi3.a_param = '0; mi3.a_size = '0; mi3.a_source = '0;
    mi3.a_address = '0; mi3.a_mask = '0; mi3.a_data = '0; mi3.a_corrupt = '0; mi3.d_ready = '0;
    si3.a_ready = 1'b1;
    si3.d_valid = '0; si3.d_source = '0; si3.d_opcode = '0; si3.d_param = '0; si3.d_size = '0;
    si3.d_denied = '0; si3.d_data = '0; si3.d_corrupt = '0;

    for (int c = 0; c < 2; c++) begin
      settle();
      chk("rst_ready", mi.a_ready, 2'b00);
      advance();
    end
    rst = 1'b0;

    // alternating Gets from both masters
    t1_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    t1_src = '{5'h00, 5'h01, 5'h12, 5'h01};
    set_req(0, 1'b1, 3'd4, 4'd2, 4'h1, 32'hA0);
    set_req(1, 1'b1, 3'd4, 4'd2, 4'h2, 32'hA1);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("rr_ready", mi.a_ready, t1_rdy[c]);
      if (c == 0) chk("rst_svalid", si.a_valid[0], 1'b0);
      else        chk("rr_source", si.a_source[0], t1_src[c]);
      advance();
    end

    // M1 4-beat PutFull locks out M0's Get
    do_reset();
    set_req(0, 1'b0, 3'd4, 4'd2, 4'h1, 32'hA0);
    set_req(1, 1'b1, 3'd0, 4'd4, 4'h2, 32'hB000_0000);
    settle();
    chk("burst_first", mi.a_ready, 2'b10);
    advance();
    set_req(0, 1'b1, 3'd4, 4'd2, 4'h1, 32'hA0);
    for (int c = 1; c < 4; c++) begin
      mi.a_data[1] = 32'hB000_0000 + c;
      settle();
      chk("burst_lock", mi.a_ready, 2'b10);
      chk("burst_src", si.a_source[0], 5'h12);
      advance();
    end
    settle();
    chk("burst_after", mi.a_ready, 2'b01);
    chk("burst_last", si.a_data[0], 32'hB000_0003);
    advance();

    // slave back-pressure holds the slice
    si.a_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("bp_valid", si.a_valid[0], 1'b1);
      chk("bp_src", si.a_source[0], 5'h01);
      chk("bp_ready", mi.a_ready, 2'b00);
      advance();
    end
    si.a_ready = 1'b1;
    settle();
    chk("bp_release", mi.a_ready, 2'b10);
    advance();
    settle();
    chk("bp_next", si.a_source[0], 5'h12);
    advance();

    // D routing with per-master back-pressure
    si.d_valid = 1'b1; si.d_source = 5'b1_0011; si.d_opcode = 3'd1; si.d_data = 32'hD00D;
    mi.d_ready = 2'b01;
    si3.d_valid = 1'b1; si3.d_source = {2'b11, 4'h5};
    settle();
    chk("d_route_v", mi.d_valid, 2'b10);
    chk("d_route_src", mi.d_source[1], 4'h3);
    chk("d_route_rdy", si.d_ready[0], 1'b0);
    chk("n3_sink_rdy", si3.d_ready[0], 1'b1);
    chk("n3_sink_v", mi3.d_valid, 3'b000);
    advance();
    mi.d_ready = 2'b11;
    si3.d_source = {2'b10, 4'h5};
    settle();
    chk("d_route_rdy1", si.d_ready[0], 1'b1);
    chk("n3_m2_v", mi3.d_valid, 3'b100);
    chk("n3_m2_rdy", si3.d_ready[0], 1'b0);
    advance();
    si.d_valid = 1'b0;

    // reset in the middle of a burst
    do_reset();
    set_req(0, 1'b0, 3'd4, 4'd2, 4'h1, 32'hA0);
    set_req(1, 1'b1, 3'd0, 4'd4, 4'h2, 32'hC0);
    for (int c = 0; c < 2; c++) begin
      settle();
      advance();
    end
    rst = 1'b1;
    settle();
    chk("mid_rst_ready", mi.a_ready, 2'b00);
    advance();
    rst = 1'b0;
    set_req(0, 1'b1, 3'd4, 4'd2, 4'h1, 32'hA0);
    set_req(1, 1'b1, 3'd4, 4'd2, 4'h2, 32'hA1);
    settle();
    chk("mid_rst_svalid", si.a_valid[0], 1'b0);
    chk("mid_rst_grant", mi.a_ready, 2'b01);
    advance();

    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
